riscv_int_ctrl: RTL and testbench

RISCV_INT_CTRL -- requirements
Module: riscv_int_ctrl

---
 rtl/riscv_int_ctrl.sv | 111 +++++++++++
 tb/tb_riscv_int_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_int_ctrl.sv
// Machine-level interrupt controller: picks the lowest enabled pending line,
// raises a one-cycle take pulse, waits for mret and then acknowledges the line.
module riscv_int_ctrl #(
  parameter int N_IRQ = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_IRQ-1:0] irq_i,
  input  logic [31:0]      mie_i,
  input  logic             stall_i,
  input  logic             mret_i,
  output logic             int_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             busy_o
);

  localparam logic [31:0] MCAUSE_BASE = 32'h8000_0010;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t             r_state;
  logic [3:0]         r_k;
  logic               r_int;
  logic               r_busy;
  logic [31:0]        r_mcause;
  logic [N_IRQ-1:0]   r_ack;

  logic [N_IRQ-1:0]   w_pending;
  logic               w_any;
  logic [3:0]         w_sel;
  logic [N_IRQ-1:0]   w_ack_onehot;
  logic               w_unused_mie;

  assign w_pending    = irq_i & mie_i[N_IRQ-1:0];
  assign w_any        = |w_pending;
  assign w_unused_mie = |mie_i[31:N_IRQ];

  // Priority encoder: scanning downward leaves the lowest pending index selected.
  always_comb begin
    w_sel = 4'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      w_sel = w_pending[i] ? 4'(i) : w_sel;
    end
  end

  // One-hot decode of the latched line for the acknowledge pulse.
  always_comb begin
    w_ack_onehot = {N_IRQ{1'b0}};
    for (int i = 0; i < N_IRQ; i++) begin
      w_ack_onehot[i] = (r_k == 4'(i));
    end
  end

  // Handler FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= IDLE;
      r_k      <= 4'd0;
      r_int    <= 1'b0;
      r_busy   <= 1'b0;
      r_mcause <= 32'h0000_0000;
      r_ack    <= {N_IRQ{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any && !stall_i) begin
            r_state  <= TAKE;
            r_k      <= w_sel;
            r_int    <= 1'b1;
            r_busy   <= 1'b1;
            r_mcause <= MCAUSE_BASE + {28'h000_0000, w_sel};
          end
        end
        TAKE: begin
          r_state <= SERVICE;
          r_int   <= 1'b0;
        end
        SERVICE: begin
          // Requests are deliberately not looked at here: no nesting.
          if (mret_i) begin
            r_state <= ACK;
            r_ack   <= w_ack_onehot;
          end
        end
        ACK: begin
          r_state <= IDLE;
          r_ack   <= {N_IRQ{1'b0}};
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_int   <= 1'b0;
          r_busy  <= 1'b0;
          r_ack   <= {N_IRQ{1'b0}};
        end
      endcase
    end
  end

  assign int_o     = r_int;
  assign mcause_o  = r_mcause;
  assign irq_ack_o = r_ack;
  assign busy_o    = r_busy;

endmodule

// File: tb/tb_riscv_int_ctrl.sv
// Bench for riscv_int_ctrl: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against an event-timestamp model.
module tb_riscv_int_ctrl;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic [N-1:0]  irq_i = '0;
  logic [31:0]   mie_i = '0;
  logic          stall_i = 1'b0;
  logic          mret_i = 1'b0;
  logic          int_o;
  logic [31:0]   mcause_o;
  logic [N-1:0]  irq_ack_o;
  logic          busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  riscv_int_ctrl #(.N_IRQ(N)) dut (
    .clk(clk), .rstn(rstn), .irq_i(irq_i), .mie_i(mie_i), .stall_i(stall_i),
    .mret_i(mret_i), .int_o(int_o), .mcause_o(mcause_o), .irq_ack_o(irq_ack_o),
    .busy_o(busy_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: remembers when the handler was opened and when mret was
  // accepted, and derives every output from those edge timestamps.
  int  t = 0;
  bit  m_open = 1'b0;
  bit  m_took = 1'b0;
  int  m_take_at = -10;
  int  m_mret_at = -10;
  int  m_k = 0;
  logic [N-1:0] pend;
  assign pend = irq_i & mie_i[N-1:0];

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      t <= 0; m_open <= 1'b0; m_took <= 1'b0;
      m_take_at <= -10; m_mret_at <= -10; m_k <= 0;
    end else begin
      t <= t + 1;
      if (!m_open) begin
        if (pend != '0 && !stall_i) begin
          m_open <= 1'b1; m_took <= 1'b1;
          m_take_at <= t + 1; m_mret_at <= -10; m_k <= lowest(pend);
        end
      end else if (m_mret_at < 0) begin
        // mret counts only once the take cycle is over
        if (mret_i && (t + 1 >= m_take_at + 2)) m_mret_at <= t + 1;
      end else if (t + 1 == m_mret_at + 1) begin
        m_open <= 1'b0;
      end
    end
  end

  // Compare process: DUT outputs against the model on every falling edge.
  always @(negedge clk) begin
    if (rstn) begin
      logic [N-1:0] exp_ack;
      exp_ack = (m_open && t == m_mret_at) ? (16'd1 << m_k) : 16'd0;
      chk("m_int",    {31'd0, int_o},     {31'd0, (m_open && t == m_take_at)});
      chk("m_busy",   {31'd0, busy_o},    {31'd0, m_open});
      chk("m_ack",    {16'd0, irq_ack_o}, {16'd0, exp_ack});
      chk("m_mcause", mcause_o, m_took ? (32'h8000_0010 + 32'(m_k)) : 32'h0);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic finish_handler();
    irq_i = '0;
    cyc();
    mret_i = 1'b1;
    cyc();
    mret_i = 1'b0;
    cyc();
    cyc();
  endtask

  initial begin
    #1 rstn = 1'b0;
    #1;
    chk("rst_int", {31'd0, int_o}, 32'd0);
    chk("rst_mcause", mcause_o, 32'h0);
    chk("rst_ack", {16'd0, irq_ack_o}, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    cyc(); cyc();
    rstn = 1'b1;
    cyc();

    // single line 2, mret ignored during TAKE
    mie_i = 32'h4; irq_i = 16'h0004;
    cyc();
    chk("t29_int", {31'd0, int_o}, 32'd1);
    chk("t29_mcause", mcause_o, 32'h8000_0012);
    chk("t29_busy", {31'd0, busy_o}, 32'd1);
    irq_i = '0; mret_i = 1'b1;
    cyc();
    chk("t29_int_once", {31'd0, int_o}, 32'd0);
    chk("t29_noack_take", {16'd0, irq_ack_o}, 32'd0);
    cyc();
    mret_i = 1'b0;
    chk("t29_ack", {16'd0, irq_ack_o}, 32'h4);
    cyc();
    chk("t29_ack_once", {16'd0, irq_ack_o}, 32'd0);
    chk("t29_idle", {31'd0, busy_o}, 32'd0);

    // lines 3 and 5: priority, then line 5 after line 3 clears
    irq_i = 16'h0028; mie_i = 32'hFFFF;
    cyc();
    chk("t30_mcause", mcause_o, 32'h8000_0013);
    cyc();
    mret_i = 1'b1;
    cyc();
    mret_i = 1'b0;
    chk("t30_ack", {16'd0, irq_ack_o}, 32'h8);
    irq_i = 16'h0020;
    cyc();
    chk("t30_gap", {31'd0, int_o}, 32'd0);
    cyc();
    chk("t30_retake", {31'd0, int_o}, 32'd1);
    chk("t30_mcause2", mcause_o, 32'h8000_0015);
    finish_handler();

    // masked line 0 stays quiet, then is taken once enabled
    irq_i = 16'h0001; mie_i = 32'h0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("t31_masked", {31'd0, int_o}, 32'd0);
    end
    mie_i = 32'h1;
    cyc();
    chk("t31_int", {31'd0, int_o}, 32'd1);
    chk("t31_mcause", mcause_o, 32'h8000_0010);
    finish_handler();

    // stall holds off the take; stall is ignored once in TAKE
    irq_i = 16'h0002; mie_i = 32'hFFFF; stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t32_stalled", {31'd0, int_o}, 32'd0);
    end
    stall_i = 1'b0;
    cyc();
    chk("t32_int", {31'd0, int_o}, 32'd1);
    chk("t32_mcause", mcause_o, 32'h8000_0011);
    stall_i = 1'b1;
    cyc();
    chk("t32_service", {31'd0, busy_o}, 32'd1);
    stall_i = 1'b0;
    finish_handler();

    // mret in IDLE is a no-op; no nesting while serviced
    irq_i = '0; mret_i = 1'b1;
    cyc();
    mret_i = 1'b0;
    chk("t33_idle_mret_busy", {31'd0, busy_o}, 32'd0);
    chk("t33_idle_mret_ack", {16'd0, irq_ack_o}, 32'd0);
    irq_i = 16'h0004;
    cyc();
    irq_i = 16'h0001;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t33_nonest", {31'd0, int_o}, 32'd0);
    end
    mret_i = 1'b1;
    cyc();
    mret_i = 1'b0;
    chk("t33_ack", {16'd0, irq_ack_o}, 32'h4);
    cyc();
    chk("t33_back_idle", {31'd0, busy_o}, 32'd0);
    cyc();
    chk("t33_retake", {31'd0, int_o}, 32'd1);
    chk("t33_mcause", mcause_o, 32'h8000_0010);
    finish_handler();

    // asynchronous reset mid-SERVICE, then take from the first edge after release
    irq_i = 16'h0002;
    cyc(); cyc();
    #2 rstn = 1'b0;
    #1;
    chk("t34_int", {31'd0, int_o}, 32'd0);
    chk("t34_mcause", mcause_o, 32'h0);
    chk("t34_busy", {31'd0, busy_o}, 32'd0);
    chk("t34_ack", {16'd0, irq_ack_o}, 32'd0);
    mret_i = 1'b1;
    cyc(); cyc();
    mret_i = 1'b0;
    chk("t34_ack_hold", {16'd0, irq_ack_o}, 32'd0);
    rstn = 1'b1;
    cyc();
    chk("t28_first_edge", {31'd0, int_o}, 32'd1);
    chk("t28_mcause", mcause_o, 32'h8000_0011);
    finish_handler();

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      irq_i   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      mie_i   = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_FFFF;
      stall_i = ($urandom_range(0, 3) == 0);
      mret_i  = ($urandom_range(0, 4) == 0);
      if (c == 1500) rstn = 1'b0;
      if (c == 1503) rstn = 1'b1;
      cyc();
    end
    irq_i = '0; mret_i = 1'b0; stall_i = 1'b0;
    cyc(); cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
